memory_loader: RTL and testbench

Front-end stage for the accumulator datapath: accepts a stream of 16-bit words over a valid/ready handshake, writes them into the shared 32×16 data memory at addresses 0..31, then hands the memory port to the accumulator top level and releases it from reset. It watches the accumulator's `Ready`, reports completion, and reclaims the memory port afterwards. It owns the only path into the memory, arbitrating between its own load writes and the accumulator's read/write traffic.

---
 rtl/memory_loader_if.sv | 37 +++
 rtl/memory_loader.sv | 118 +++++++++++
 tb/tb_memory_loader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_loader_if.sv
// Handshake, accumulator-side and memory-side signals of memory_loader.
// master = the loader itself; slave = the surrounding upstream/accumulator/memory.
interface memory_loader_if #(
  parameter int AW    = 5,
  parameter int WIDTH = 16
);
  logic             Start;
  logic             InValid;
  logic [WIDTH-1:0] InData;
  logic             InReady;
  logic             TopReset;
  logic             TopReady;
  logic [AW-1:0]    TopAddress;
  logic             TopReadEnable;
  logic             TopWriteEnable;
  logic [WIDTH-1:0] TopDataIN;
  logic [AW-1:0]    MemAddress;
  logic             MemReadEnable;
  logic             MemWriteEnable;
  logic [WIDTH-1:0] MemDataIN;
  logic             Done;
  logic [WIDTH-1:0] Checksum;

  modport master (
    input  Start, InValid, InData, TopReady, TopAddress,
           TopReadEnable, TopWriteEnable, TopDataIN,
    output InReady, TopReset, MemAddress, MemReadEnable,
           MemWriteEnable, MemDataIN, Done, Checksum
  );

  modport slave (
    output Start, InValid, InData, TopReady, TopAddress,
           TopReadEnable, TopWriteEnable, TopDataIN,
    input  InReady, TopReset, MemAddress, MemReadEnable,
           MemWriteEnable, MemDataIN, Done, Checksum
  );
endinterface

// File: rtl/memory_loader.sv
// Loads DEPTH words into the shared data memory, then runs the accumulator and reclaims the port.
// Optional feature: define LOADER_CHECKSUM_EN to enable the running sum of loaded words.
module memory_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int WIDTH = 16
) (
  input  logic Clock,
  input  logic Reset,
  memory_loader_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, DONE} state_t;

  localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);

  state_t           state_reg, state_next;
  logic [AW:0]      cnt_reg, cnt_next;
  logic             wr_valid_reg;
  logic [AW-1:0]    wr_addr_reg;
  logic [WIDTH-1:0] wr_data_reg;
  logic             run_armed_reg;
  logic             top_reset_reg;
  logic             done_reg;
  logic             accept;
  logic             start_ok;

  assign accept   = (state_reg == LOAD) && bus.InValid;
  assign start_ok = bus.Start && ((state_reg == IDLE) || (state_reg == DONE));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start_ok) begin
          state_next = LOAD;
          cnt_next   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_IDX) state_next = DRAIN;
        end
      end
      DRAIN:   state_next = RUN;
      // run_armed_reg is low in the first RUN cycle so a stale Ready is ignored
      RUN:     if (run_armed_reg && bus.TopReady) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.InReady        = (state_reg == LOAD);
    bus.MemAddress     = '0;
    bus.MemReadEnable  = 1'b0;
    bus.MemWriteEnable = 1'b0;
    bus.MemDataIN      = '0;
    case (state_reg)
      LOAD, DRAIN: begin
        bus.MemAddress     = wr_addr_reg;
        bus.MemWriteEnable = wr_valid_reg;
        bus.MemDataIN      = wr_data_reg;
      end
      RUN: begin
        bus.MemAddress     = bus.TopAddress;
        bus.MemReadEnable  = bus.TopReadEnable;
        bus.MemWriteEnable = bus.TopWriteEnable;
        bus.MemDataIN      = bus.TopDataIN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      wr_valid_reg  <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      run_armed_reg <= 1'b0;
      top_reset_reg <= 1'b1;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      wr_valid_reg  <= accept;
      if (accept) begin
        wr_addr_reg <= cnt_reg[AW-1:0];
        wr_data_reg <= bus.InData;
      end
      run_armed_reg <= (state_reg == RUN);
      // Registered so the accumulator reset and Done never glitch on state decode
      top_reset_reg <= (state_next != RUN);
      done_reg      <= (state_next == DONE);
    end
  end

  assign bus.TopReset = top_reset_reg;
  assign bus.Done     = done_reg;

`ifdef LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] checksum_reg;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)         checksum_reg <= '0;
    else if (start_ok) checksum_reg <= '0;
    else if (accept)   checksum_reg <= checksum_reg + bus.InData;
  end

  assign bus.Checksum = checksum_reg;
`else
  assign bus.Checksum = '0;
`endif

endmodule

// File: tb/tb_memory_loader.sv
// Directed bench for memory_loader: full-rate and throttled loads, RUN pass-through,
// Ready masking, Start filtering and asynchronous reset mid-load.
module tb_memory_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t wr_q[$];

  memory_loader_if #(.AW(5), .WIDTH(16)) bus ();

  memory_loader #(.DEPTH(32), .AW(5), .WIDTH(16)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.MemWriteEnable === 1'b1)
      wr_q.push_back('{bus.MemAddress, bus.MemDataIN, cyc});

  function automatic logic [15:0] exp_ck(input logic [15:0] v);
`ifdef LOADER_CHECKSUM_EN
    return v;
`else
    return 16'h0000 & v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic load_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.InValid = 1'b1;
      bus.InData  = base + 16'(i);
      tick();
    end
    bus.InValid = 1'b0;
  endtask

  // first_cyc: expected posedge count at which word 0 is seen on the memory port
  task automatic check_writes(input logic [15:0] base, input int n, input int step, input int first_cyc);
    check("wr_count", wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), {27'd0, wr_q[i].addr}, i);
      check($sformatf("wr_data[%0d]", i), {16'd0, wr_q[i].data}, {16'd0, base + 16'(i)});
      check($sformatf("wr_cyc[%0d]", i), wr_q[i].cyc, first_cyc + i * step);
    end
  endtask

  int start_cyc;

  initial begin
    bus.Start = 0; bus.InValid = 0; bus.InData = 0; bus.TopReady = 0;
    bus.TopAddress = 0; bus.TopReadEnable = 0; bus.TopWriteEnable = 0; bus.TopDataIN = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_inready", bus.InReady, 0);
    check("rst_topreset", bus.TopReset, 1);
    check("rst_done", bus.Done, 0);
    check("rst_memwe", bus.MemWriteEnable, 0);
    check("rst_memre", bus.MemReadEnable, 0);
    check("rst_memaddr", bus.MemAddress, 0);
    check("rst_memdata", bus.MemDataIN, 0);
    check("rst_checksum", bus.Checksum, 0);
    rst = 1'b0;
    tick();

    // Full-rate load of 0x0001..0x0020
    pulse_start();
    start_cyc = cyc;
    check("load_inready", bus.InReady, 1);
    check("load_topreset", bus.TopReset, 1);
    load_words(16'h0001, 32);
    check("drain_inready", bus.InReady, 0);
    check("drain_memwe", bus.MemWriteEnable, 1);
    check("drain_memaddr", bus.MemAddress, 31);
    check("drain_memdata", bus.MemDataIN, 16'h0020);
    check("drain_topreset", bus.TopReset, 1);
    tick();
    check("run_topreset", bus.TopReset, 0);
    check_writes(16'h0001, 32, 1, start_cyc + 1);
    check("ck_full", bus.Checksum, exp_ck(16'h0210));
    $display("load1 writes=%0d first_cyc=%0d", wr_q.size(), start_cyc + 1);

    // RUN pass-through, plus an early Ready that must be ignored
    bus.TopAddress = 5; bus.TopWriteEnable = 1; bus.TopDataIN = 16'hBEEF; bus.TopReady = 1;
    #1;
    check("pass_addr", bus.MemAddress, 5);
    check("pass_we", bus.MemWriteEnable, 1);
    check("pass_data", bus.MemDataIN, 16'hBEEF);
    check("pass_re", bus.MemReadEnable, 0);
    tick();
    bus.TopReady = 0; bus.TopWriteEnable = 0; bus.TopReadEnable = 1; bus.TopAddress = 9;
    #1;
    check("first_ready_done", bus.Done, 0);
    check("first_ready_topreset", bus.TopReset, 0);
    check("pass_re2", bus.MemReadEnable, 1);
    check("pass_addr2", bus.MemAddress, 9);
    bus.TopReadEnable = 0;
    repeat (9) tick();
    pulse_start();
    check("run_start_done", bus.Done, 0);
    check("run_start_inready", bus.InReady, 0);
    check("run_start_topreset", bus.TopReset, 0);
    bus.TopReady = 1;
    tick();
    bus.TopReady = 0;
    check("done_done", bus.Done, 1);
    check("done_topreset", bus.TopReset, 1);
    check("done_memwe", bus.MemWriteEnable, 0);
    check("done_memaddr", bus.MemAddress, 0);
    tick();
    check("done_hold", bus.Done, 1);
    $display("run1 done=%0b", bus.Done);

    // Start in DONE, load with InValid toggling every other cycle
    wr_q.delete();
    pulse_start();
    start_cyc = cyc;
    check("restart_done", bus.Done, 0);
    check("restart_inready", bus.InReady, 1);
    check("restart_ck", bus.Checksum, 0);
    for (int k = 0; k < 63; k++) begin
      bus.InValid = (k % 2 == 0);
      bus.InData  = (k % 2 == 0) ? 16'h0100 + 16'(k / 2) : 16'hDEAD;
      tick();
      if (k == 61) check("pre32_inready", bus.InReady, 1);
    end
    bus.InValid = 0;
    check("tog_drain_inready", bus.InReady, 0);
    check("tog_drain_memaddr", bus.MemAddress, 31);
    check("tog_drain_memwe", bus.MemWriteEnable, 1);
    tick();
    check_writes(16'h0100, 32, 2, start_cyc + 1);
    check("ck_toggle", bus.Checksum, exp_ck(16'h21F0));
    $display("load2 writes=%0d", wr_q.size());
    bus.TopReady = 1;
    repeat (2) tick();
    bus.TopReady = 0;
    check("run2_done", bus.Done, 1);

    // Reset after 10 accepted words, then reload from address 0
    wr_q.delete();
    pulse_start();
    load_words(16'h0200, 10);
    check("pend_memwe", bus.MemWriteEnable, 1);
    rst = 1'b1;
    #1;
    check("arst_inready", bus.InReady, 0);
    check("arst_topreset", bus.TopReset, 1);
    check("arst_memwe", bus.MemWriteEnable, 0);
    check("arst_memaddr", bus.MemAddress, 0);
    check("arst_done", bus.Done, 0);
    @(negedge clk);
    rst = 1'b0;
    check("arst_writes", wr_q.size(), 9);
    $display("reset_mid_load writes=%0d", wr_q.size());
    wr_q.delete();
    tick();
    pulse_start();
    start_cyc = cyc;
    load_words(16'h0300, 32);
    tick();
    check("reload_topreset", bus.TopReset, 0);
    check_writes(16'h0300, 32, 1, start_cyc + 1);
    check("ck_reload", bus.Checksum, exp_ck(16'h61F0));
    $display("load3 writes=%0d", wr_q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
